// File: rtl/connect4_pkg.sv
// Shared Connect-4 board dimensions, player codes and turn sequencing states.
package connect4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  localparam logic [COLS-1:0] ALL_FULL = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } player_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    PLACE,
    RANDOM,
    CHECK,
    SWITCH,
    OVER
  } turn_state_t;

  function automatic player_t other_player(input player_t p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: load to TURN_TICKS, decrement on tick, flag the tick that empties it.
module turn_timer #(
  parameter  int TURN_TICKS = 10,
  localparam int TW         = $clog2(TURN_TICKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          expire
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(TURN_TICKS);
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The tick that takes the count from 1 to 0 is the one that forces an auto-move.
  assign expire = tick && (count == TW'(1));

endmodule

// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: human pick or timeout auto-move, win/draw check, player swap.
module turn_controller
  import connect4_pkg::*;
#(
  parameter  int TURN_TICKS = 10,
  localparam int TW         = $clog2(TURN_TICKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          tick_i,
  input  logic          col_valid,
  input  logic [2:0]    col_sel,
  input  logic [6:0]    col_full,
  input  logic          drop_done,
  input  logic          rand_done,
  input  logic          check_done,
  input  logic          win,
  output logic          board_clr,
  output logic [1:0]    jugador,
  output logic          place_req,
  output logic [2:0]    place_col,
  output logic          rand_en,
  output logic          check_req,
  output logic [TW-1:0] time_left,
  output logic          game_over,
  output logic [1:0]    winner
);

  turn_state_t state;

  logic       in_wait;
  logic       draw;
  logic       legal_pick;
  logic [7:0] col_blocked;
  logic       new_game;
  logic       timer_load;
  logic       timer_tick;
  logic       timer_expire;

  // Column index 7 is treated as a permanently full column so one lookup rejects both cases.
  assign col_blocked = {1'b1, col_full};
  assign in_wait     = (state == WAIT_MOVE);
  assign draw        = in_wait && (col_full == ALL_FULL);
  assign legal_pick  = in_wait && col_valid && !col_blocked[col_sel];
  assign new_game    = start && ((state == IDLE) || (state == OVER));

  // A legal human pick on the final tick wins, so that tick never reaches the timer.
  assign timer_load = new_game || (state == SWITCH);
  assign timer_tick = in_wait && tick_i && !draw && !legal_pick;

  turn_timer #(
    .TURN_TICKS(TURN_TICKS)
  ) timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .tick  (timer_tick),
    .count (time_left),
    .expire(timer_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      board_clr <= 1'b0;
      jugador   <= EMPTY;
      place_req <= 1'b0;
      place_col <= '0;
      rand_en   <= 1'b0;
      check_req <= 1'b0;
      game_over <= 1'b0;
      winner    <= EMPTY;
    end else begin
      board_clr <= 1'b0;
      place_req <= 1'b0;
      check_req <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            board_clr <= 1'b1;
            jugador   <= P1;
            winner    <= EMPTY;
            game_over <= 1'b0;
            state     <= WAIT_MOVE;
          end
        end
        WAIT_MOVE: begin
          if (draw) begin
            game_over <= 1'b1;
            winner    <= EMPTY;
            state     <= OVER;
          end else if (legal_pick) begin
            place_col <= col_sel;
            place_req <= 1'b1;
            state     <= PLACE;
          end else if (timer_expire) begin
            rand_en <= 1'b1;
            state   <= RANDOM;
          end
        end
        PLACE: begin
          if (drop_done) begin
            check_req <= 1'b1;
            state     <= CHECK;
          end
        end
        RANDOM: begin
          if (rand_done) begin
            rand_en   <= 1'b0;
            check_req <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (check_done) begin
            if (win) begin
              game_over <= 1'b1;
              winner    <= jugador;
              state     <= OVER;
            end else begin
              state <= SWITCH;
            end
          end
        end
        SWITCH: begin
          jugador <= other_player(player_t'(jugador));
          state   <= WAIT_MOVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// Randomised game-level bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_turn_controller;
  import connect4_pkg::*;

  localparam int TT = 3;
  localparam int TW = $clog2(TT + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start, tick_i, col_valid, drop_done, rand_done, check_done, win;
  logic [2:0]    col_sel;
  logic [6:0]    col_full;
  logic          board_clr, place_req, rand_en, check_req, game_over;
  logic [1:0]    jugador, winner;
  logic [2:0]    place_col;
  logic [TW-1:0] time_left;

  turn_controller #(.TURN_TICKS(TT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tick_i    (tick_i),
    .col_valid (col_valid),
    .col_sel   (col_sel),
    .col_full  (col_full),
    .drop_done (drop_done),
    .rand_done (rand_done),
    .check_done(check_done),
    .win       (win),
    .board_clr (board_clr),
    .jugador   (jugador),
    .place_req (place_req),
    .place_col (place_col),
    .rand_en   (rand_en),
    .check_req (check_req),
    .time_left (time_left),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_CLR, EV_PLACE, EV_RAND_ON, EV_RAND_OFF, EV_CHECK, EV_OVER} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       col;
    int       player;
    int       tl;
    int       win_p;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  passes = 0;

  function automatic void push(input ev_kind_t k, input int col, input int pl, input int tl,
                               input int wp);
    ev_t e;
    e.kind = k; e.cyc = cyc; e.col = col; e.player = pl; e.tl = tl; e.win_p = wp;
    expq.push_back(e);
  endfunction

  function automatic void chk(input string name, input int got, input int req);
    checks++;
    if (got == req) begin
      passes++;
      $display("ok   %s got=%0d", name, got);
    end else begin
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endfunction

  task automatic observe(input ev_kind_t k);
    ev_t e;
    bit  ok;
    checks++;
    if (expq.size() == 0) begin
      $display("FAIL %s cyc=%0d got unexpected event, required none", k.name(), cyc);
      return;
    end
    e  = expq.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc) && (int'(jugador) == e.player) &&
         (int'(time_left) == e.tl);
    case (k)
      EV_CLR:               ok = ok && (winner == 2'b00) && !game_over;
      EV_PLACE:             ok = ok && (int'(place_col) == e.col);
      EV_RAND_OFF, EV_CHECK: ok = ok && !rand_en;
      EV_OVER:              ok = ok && (int'(winner) == e.win_p);
      default:              ok = ok && !place_req;
    endcase
    if (ok) passes++;
    $display("%s %s cyc=%0d jug=%0d tl=%0d col=%0d win=%0d ; required %s cyc=%0d jug=%0d tl=%0d col=%0d win=%0d",
             ok ? "ok  " : "FAIL", k.name(), cyc, jugador, time_left, place_col, winner,
             e.kind.name(), e.cyc, e.player, e.tl, e.col, e.win_p);
  endtask

  // Monitor: every output event is matched against the oldest expectation.
  initial begin
    logic prev_rand, prev_over;
    prev_rand = 1'b0;
    prev_over = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (board_clr) observe(EV_CLR);
        if (place_req) observe(EV_PLACE);
        if (rand_en && !prev_rand) observe(EV_RAND_ON);
        if (!rand_en && prev_rand) observe(EV_RAND_OFF);
        if (check_req) observe(EV_CHECK);
        if (game_over && !prev_over) observe(EV_OVER);
      end
      prev_rand = rand_en;
      prev_over = game_over;
    end
  end

  task automatic edge_();
    @(posedge clk);
    #1;
    start = 0; tick_i = 0; col_valid = 0; drop_done = 0; rand_done = 0; check_done = 0; win = 0;
  endtask

  function automatic int legal_col(input logic [6:0] mask);
    int c;
    c = $urandom_range(0, 6);
    while (mask[c]) c = $urandom_range(0, 6);
    return c;
  endfunction

  function automatic int illegal_col(input logic [6:0] mask);
    int c;
    if (mask == 7'h00 || $urandom_range(0, 1) == 0) return 7;
    c = $urandom_range(0, 6);
    while (!mask[c]) c = $urandom_range(0, 6);
    return c;
  endfunction

  // Inputs that must have no effect outside WAIT_MOVE / IDLE / OVER.
  task automatic stray(input bit handshakes);
    tick_i    = 1'($urandom_range(0, 1));
    col_valid = 1'($urandom_range(0, 1));
    col_sel   = 3'($urandom_range(0, 7));
    start     = ($urandom_range(0, 7) == 0);
    if (handshakes) begin
      drop_done = 1'($urandom_range(0, 1));
      rand_done = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic play_game();
    int         pl, left, c, n;
    logic [6:0] mask;
    bit         done, by_hand, ticked, w;
    start = 1; edge_(); push(EV_CLR, 0, 1, TT, 0);
    pl = 1; left = TT;
    for (int t = 0; t < 60; t++) begin
      if (t == 59 || $urandom_range(0, 19) == 0) begin
        col_full = 7'h7F; edge_(); push(EV_OVER, 0, pl, left, 0);
        col_full = 7'h00;
        return;
      end
      mask = 7'($urandom_range(0, 126));
      col_full = mask;
      done = 0; by_hand = 0;
      while (!done) begin
        n = $urandom_range(0, 9);
        tick_i = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
          drop_done = 1; rand_done = 1; check_done = 1;
        end
        if (n < 2) begin
          c = legal_col(mask);
          col_valid = 1; col_sel = 3'(c);
          edge_(); push(EV_PLACE, c, pl, left, 0);
          by_hand = 1; done = 1;
        end else begin
          if (n < 5) begin
            col_valid = 1; col_sel = 3'(illegal_col(mask));
          end
          ticked = tick_i;
          edge_();
          if (ticked) begin
            left--;
            if (left == 0) begin
              push(EV_RAND_ON, 0, pl, 0, 0);
              done = 1;
            end
          end
        end
      end
      repeat ($urandom_range(0, 3)) begin stray(0); edge_(); end
      if (by_hand) begin
        drop_done = 1; edge_(); push(EV_CHECK, 0, pl, left, 0);
      end else begin
        rand_done = 1; edge_(); push(EV_RAND_OFF, 0, pl, 0, 0); push(EV_CHECK, 0, pl, 0, 0);
      end
      repeat ($urandom_range(0, 3)) begin stray(1); edge_(); end
      w = ($urandom_range(0, 6) == 0);
      check_done = 1; win = w;
      edge_();
      if (w) begin
        push(EV_OVER, 0, pl, left, pl);
        return;
      end
      stray(1);
      edge_();
      pl = 3 - pl; left = TT;
    end
  endtask

  initial begin
    reset = 1; start = 0; tick_i = 0; col_valid = 0; col_sel = 0; col_full = 0;
    drop_done = 0; rand_done = 0; check_done = 0; win = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_jugador", int'(jugador), 0);
    chk("rst_time_left", int'(time_left), 0);
    chk("rst_outputs", int'({board_clr, place_req, rand_en, check_req, game_over, winner}), 0);
    edge_();

    // Directed: illegal picks, human move on the final tick, timeout, win, restart, draw.
    start = 1; edge_(); push(EV_CLR, 0, 1, TT, 0);
    col_full = 7'b0000100; col_valid = 1; col_sel = 3'd2; edge_();
    col_valid = 1; col_sel = 3'd7; edge_();
    tick_i = 1; edge_();
    tick_i = 1; edge_();
    col_valid = 1; col_sel = 3'd3; tick_i = 1; edge_(); push(EV_PLACE, 3, 1, 1, 0);
    drop_done = 1; edge_(); push(EV_CHECK, 0, 1, 1, 0);
    check_done = 1; edge_();
    edge_();
    repeat (TT - 1) begin tick_i = 1; edge_(); end
    tick_i = 1; edge_(); push(EV_RAND_ON, 0, 2, 0, 0);
    repeat (2) edge_();
    rand_done = 1; edge_(); push(EV_RAND_OFF, 0, 2, 0, 0); push(EV_CHECK, 0, 2, 0, 0);
    check_done = 1; win = 1; edge_(); push(EV_OVER, 0, 2, 0, 2);
    edge_();
    start = 1; edge_(); push(EV_CLR, 0, 1, TT, 0);
    col_full = 7'h7F; edge_(); push(EV_OVER, 0, 1, TT, 0);
    col_full = 7'h00;
    edge_();

    // Directed: asynchronous reset in the middle of an auto-move.
    start = 1; edge_(); push(EV_CLR, 0, 1, TT, 0);
    repeat (TT - 1) begin tick_i = 1; edge_(); end
    tick_i = 1; edge_(); push(EV_RAND_ON, 0, 1, 0, 0);
    edge_();
    #1 reset = 1;
    #1;
    chk("arst_rand_en", int'(rand_en), 0);
    chk("arst_jugador", int'(jugador), 0);
    chk("arst_game_over", int'(game_over), 0);
    chk("arst_time_left", int'(time_left), 0);
    @(posedge clk);
    #1 reset = 0;
    edge_();

    for (int g = 0; g < 30; g++) begin
      play_game();
      repeat ($urandom_range(1, 3)) begin stray(1); start = 0; edge_(); end
    end

    repeat (4) edge_();
    chk("drain_pending", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d pending=%0d required finish", cyc, expq.size());
    $fatal(1, "timeout");
  end

endmodule
